program_sequencer: RTL and testbench

- Fetch-side stage directly upstream of the instruction decoder.
- Owns the program counter and drives pm_addr to the synchronous program ROM. The ROM's data output becomes next_instr, which the decoder latches into ir.
- Consumes the decoder's jmp, jmp_nz and ir_nibble outputs plus the datapath zero flag. Resolves branches and absorbs program-memory wait states.
- Tells the decoder when the instruction in ir is valid.

---
 rtl/program_sequencer_pkg.sv | 15 +
 rtl/sat_counter.sv | 23 ++
 rtl/program_sequencer.sv | 132 +++++++++++++
 tb/tb_program_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_sequencer_pkg.sv
// Shared definitions for the fetch side: address/counter widths, reset vector and
// sequencer state encoding. Also used by the decoder and the program ROM.
package program_sequencer_pkg;

    localparam int ADDR_W     = 8;
    localparam int CNT_W      = 8;
    localparam int RESET_ADDR = 0;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } ps_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear. It holds at all-ones and
// does not wrap.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// Program sequencer: owns the pc, drives the program ROM address, resolves branches
// and absorbs ROM wait states. Breakpoint/halt support is built only with BREAKPOINT_EN.
//
//   state | meaning
//   BOOT  | ir is stale; keep re-issuing pc until the ROM answers
//   RUN   | ir valid whenever pm_ready; next address from the branch mux
//   HALT  | breakpoint hit; pc and counters frozen until resume (BREAKPOINT_EN only)
module program_sequencer #(
    parameter int ADDR_W = program_sequencer_pkg::ADDR_W,
    parameter int CNT_W  = program_sequencer_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sync_reset,
    input  logic              jmp,
    input  logic              jmp_nz,
    input  logic [3:0]        ir_nibble,
    input  logic              dont_jmp,
    input  logic              pm_ready,
`ifdef BREAKPOINT_EN
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic              bp_arm,
    input  logic              resume,
    output logic              halted,
`endif
    output logic [ADDR_W-1:0] pm_addr,
    output logic [ADDR_W-1:0] pc,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] from_PS,
    output logic [CNT_W-1:0]  jump_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    import program_sequencer_pkg::*;

    localparam logic [1:0] S_BOOT = BOOT;
    localparam logic [1:0] S_RUN  = RUN;
`ifdef BREAKPOINT_EN
    localparam logic [1:0] S_HALT = HALT;
`endif

    localparam logic [ADDR_W-1:0] PC_RESET = ADDR_W'(RESET_ADDR);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       pc_load;
    logic       jump_taken;
    logic       stall;

    always_comb begin
        state_nxt   = state;
        pm_addr     = pc;
        instr_valid = 1'b0;
        pc_load     = 1'b0;
        jump_taken  = 1'b0;
        stall       = 1'b0;
        if (sync_reset) begin
            pm_addr   = PC_RESET;
            state_nxt = S_BOOT;
        end else begin
            case (state)
                S_BOOT: begin
                    if (pm_ready) state_nxt = S_RUN;
                end
                S_RUN: begin
                    if (!pm_ready) begin
                        stall = 1'b1;
                    end else begin
                        instr_valid = 1'b1;
                        pc_load     = 1'b1;
                        if (jmp || (jmp_nz && !dont_jmp)) begin
                            jump_taken = 1'b1;
                            pm_addr    = ADDR_W'(ir_nibble);
                        end else begin
                            pm_addr = pc + ADDR_W'(1);
                        end
`ifdef BREAKPOINT_EN
                        // pc stays on the breakpoint address so resume re-fetches it
                        if (bp_arm && (pc == bp_addr)) begin
                            state_nxt = S_HALT;
                            pc_load   = 1'b0;
                        end
`endif
                    end
                end
`ifdef BREAKPOINT_EN
                S_HALT: begin
                    if (resume) state_nxt = S_BOOT;
                end
`endif
                default: state_nxt = S_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_BOOT;
            pc    <= PC_RESET;
        end else begin
            state <= state_nxt;
            if (sync_reset) begin
                pc <= PC_RESET;
            end else if (pc_load) begin
                pc <= pm_addr;
            end
        end
    end

    assign from_PS = pc;

`ifdef BREAKPOINT_EN
    assign halted = (state == S_HALT);
`endif

    sat_counter #(.W(CNT_W)) u_jump_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (sync_reset),
        .inc     (jump_taken),
        .cnt     (jump_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (sync_reset),
        .inc     (stall),
        .cnt     (stall_cnt)
    );

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: directed scenarios plus random traffic compared every
// cycle against a flag-based fetch model. Define BREAKPOINT_EN to cover halt/resume.
module tb_program_sequencer;

    localparam int AW    = 8;
    localparam int CW    = 8;
    localparam int AMOD  = 1 << AW;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          sync_reset = 1'b0;
    logic          jmp = 1'b0;
    logic          jmp_nz = 1'b0;
    logic [3:0]    ir_nibble = 4'd0;
    logic          dont_jmp = 1'b0;
    logic          pm_ready = 1'b0;
    logic [AW-1:0] pm_addr;
    logic [AW-1:0] pc;
    logic          instr_valid;
    logic [AW-1:0] from_PS;
    logic [CW-1:0] jump_cnt;
    logic [CW-1:0] stall_cnt;
`ifdef BREAKPOINT_EN
    logic [AW-1:0] bp_addr = '0;
    logic          bp_arm = 1'b0;
    logic          resume = 1'b0;
    logic          halted;
`endif

    program_sequencer #(.ADDR_W(AW), .CNT_W(CW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sync_reset  (sync_reset),
        .jmp         (jmp),
        .jmp_nz      (jmp_nz),
        .ir_nibble   (ir_nibble),
        .dont_jmp    (dont_jmp),
        .pm_ready    (pm_ready),
`ifdef BREAKPOINT_EN
        .bp_addr     (bp_addr),
        .bp_arm      (bp_arm),
        .resume      (resume),
        .halted      (halted),
`endif
        .pm_addr     (pm_addr),
        .pc          (pc),
        .instr_valid (instr_valid),
        .from_PS     (from_PS),
        .jump_cnt    (jump_cnt),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // model: fetch has started (m_run), breakpoint halt (m_halt), plain integers otherwise
    int m_pc, m_jumps, m_stalls;
    bit m_run, m_halt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_jumps = 0; m_stalls = 0; m_run = 0; m_halt = 0;
    endtask

    task automatic model_outputs(output int pm, output bit iv, output bit taken);
        taken = 0;
        if (sync_reset) begin
            pm = 0; iv = 0;
        end else if (m_halt || !m_run || !pm_ready) begin
            pm = m_pc; iv = 0;
        end else begin
            iv = 1;
            taken = jmp || (jmp_nz && !dont_jmp);
            pm = taken ? int'(ir_nibble) : (m_pc + 1) % AMOD;
        end
    endtask

    task automatic check_model();
        int pm; bit iv; bit tk;
        model_outputs(pm, iv, tk);
        chk("pm_addr", 32'(pm_addr), 32'(pm));
        chk("pc", 32'(pc), 32'(m_pc));
        chk("from_PS", 32'(from_PS), 32'(m_pc));
        chk("instr_valid", 32'(instr_valid), 32'(iv));
        chk("jump_cnt", 32'(jump_cnt), 32'(m_jumps));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stalls));
`ifdef BREAKPOINT_EN
        chk("halted", 32'(halted), 32'(m_halt));
`endif
    endtask

    task automatic model_advance();
        int pm; bit iv; bit tk; bit hit;
        model_outputs(pm, iv, tk);
        hit = 0;
`ifdef BREAKPOINT_EN
        hit = bp_arm && (m_pc == int'(bp_addr));
`endif
        if (!reset_n) begin
            model_reset();
        end else if (sync_reset) begin
            model_reset();
        end else if (m_halt) begin
`ifdef BREAKPOINT_EN
            if (resume) begin m_halt = 0; m_run = 0; end
`endif
        end else if (!m_run) begin
            if (pm_ready) m_run = 1;
        end else if (!pm_ready) begin
            m_stalls = (m_stalls < CMAX) ? m_stalls + 1 : CMAX;
        end else begin
            if (tk) m_jumps = (m_jumps < CMAX) ? m_jumps + 1 : CMAX;
            if (hit) m_halt = 1;
            else     m_pc = pm;
        end
    endtask

    // called just after a falling edge: check, cross the rising edge, return at next fall
    task automatic tick();
        #1 check_model();
        @(posedge clk);
        model_advance();
        @(negedge clk);
    endtask

    task automatic set_in(input bit j, input bit jnz, input logic [3:0] nib,
                          input bit dz, input bit rdy, input bit sr);
        jmp = j; jmp_nz = jnz; ir_nibble = nib; dont_jmp = dz; pm_ready = rdy; sync_reset = sr;
    endtask

    task automatic run_straight(input int n);
        set_in(0, 0, 4'd0, 0, 1, 0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic async_pulse();
        #3 reset_n = 1'b0;
        #1 model_reset();
        chk("async_pc", 32'(pc), 32'h0);
        chk("async_pm_addr", 32'(pm_addr), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // reset state and BOOT behaviour
        set_in(0, 0, 4'd0, 0, 0, 0);
        #1;
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_pm_addr", 32'(pm_addr), 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_jump_cnt", 32'(jump_cnt), 32'h0);
        tick();
        tick();
        chk("boot_no_stall", 32'(stall_cnt), 32'h0);
        pm_ready = 1'b1;
        tick();

        // unconditional jump, then jmp+jmp_nz counted once
        run_straight(8'h31);
        chk("pc_31", 32'(pc), 32'h31);
        set_in(1, 0, 4'hA, 0, 1, 0);
        #1 chk("jmp_pm_addr", 32'(pm_addr), 32'h0A);
        tick();
        chk("jmp_pc", 32'(pc), 32'h0A);
        chk("jmp_cnt1", 32'(jump_cnt), 32'h1);
        set_in(1, 1, 4'h3, 0, 1, 0);
        tick();
        chk("both_cnt", 32'(jump_cnt), 32'h2);
        chk("both_pc", 32'(pc), 32'h03);

        // conditional jump suppressed / taken
        run_straight(13);
        set_in(0, 1, 4'h5, 1, 1, 0);
        #1 chk("jnz_suppressed", 32'(pm_addr), 32'h11);
        dont_jmp = 1'b0;
        #1 chk("jnz_taken", 32'(pm_addr), 32'h05);
        tick();
        chk("jnz_cnt", 32'(jump_cnt), 32'h3);

        // wait states with a jump pending
        run_straight(8'h3B);
        set_in(1, 0, 4'h7, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_pm_addr", 32'(pm_addr), 32'h40);
            chk("stall_valid", 32'(instr_valid), 32'h0);
            tick();
        end
        chk("stall_cnt3", 32'(stall_cnt), 32'h3);
        chk("stall_no_jump", 32'(jump_cnt), 32'h3);
        pm_ready = 1'b1;
        #1 chk("ready_target", 32'(pm_addr), 32'h07);
        tick();

        // async reset mid-run
        run_straight(8'h1C);
        chk("pc_23", 32'(pc), 32'h23);
        async_pulse();
        set_in(0, 0, 4'd0, 0, 1, 0);
        #1 chk("post_rst_valid", 32'(instr_valid), 32'h0);
        tick();
        #1 chk("run_valid", 32'(instr_valid), 32'h1);

        // address wrap
        run_straight(8'hFE);
        #1 chk("wrap_ff", 32'(pm_addr), 32'hFF);
        tick();
        #1 chk("wrap_00", 32'(pm_addr), 32'h00);
        tick();
        chk("wrap_pc", 32'(pc), 32'h00);
        chk("wrap_no_jump", 32'(jump_cnt), 32'h0);

        // synchronous reset overrides a jump
        run_straight(5);
        set_in(1, 0, 4'h9, 0, 1, 1);
        #1;
        chk("sr_pm_addr", 32'(pm_addr), 32'h0);
        chk("sr_valid", 32'(instr_valid), 32'h0);
        tick();
        chk("sr_pc", 32'(pc), 32'h0);
        chk("sr_jump_cnt", 32'(jump_cnt), 32'h0);
        set_in(0, 0, 4'd0, 0, 1, 0);
        #1 chk("sr_boot_valid", 32'(instr_valid), 32'h0);
        tick();

        // saturation
        set_in(0, 0, 4'd0, 0, 0, 0);
        for (int i = 0; i < 300; i++) tick();
        chk("stall_sat", 32'(stall_cnt), 32'hFF);
        set_in(1, 0, 4'h2, 0, 1, 0);
        for (int i = 0; i < 300; i++) tick();
        chk("jump_sat", 32'(jump_cnt), 32'hFF);

`ifdef BREAKPOINT_EN
        set_in(0, 0, 4'd0, 0, 1, 1);
        tick();
        bp_addr = 8'h07;
        bp_arm = 1'b1;
        run_straight(1);
        run_straight(8);
        chk("bp_halted", 32'(halted), 32'h1);
        chk("bp_pc", 32'(pc), 32'h07);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_frozen", 32'(pc), 32'h07);
        end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        bp_arm = 1'b0;
        #1;
        chk("resume_halted", 32'(halted), 32'h0);
        chk("resume_boot_valid", 32'(instr_valid), 32'h0);
        tick();
        #1;
        chk("resume_pc", 32'(pc), 32'h07);
        chk("resume_valid", 32'(instr_valid), 32'h1);
`endif

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            jmp        = ($urandom_range(3) == 0);
            jmp_nz     = ($urandom_range(3) == 0);
            dont_jmp   = $urandom_range(1) == 1;
            ir_nibble  = 4'($urandom_range(15));
            pm_ready   = ($urandom_range(3) != 0);
            sync_reset = ($urandom_range(79) == 0);
`ifdef BREAKPOINT_EN
            bp_arm  = $urandom_range(1) == 1;
            bp_addr = 8'($urandom_range(15));
            resume  = ($urandom_range(7) == 0);
`endif
            if ($urandom_range(199) == 0) async_pulse();
            else tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
